// File: rtl/qarctan_arbiter_pkg.sv
// Shared types and helpers for the two-requester qarctan arbiter.
// Optional statistics counters are enabled with QARCTAN_ARB_STATS_EN.
package qarctan_arbiter_pkg;

  typedef enum logic {
    S_SEL   = 1'b0,
    S_ISSUE = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ = 2;

  typedef logic arb_tag_t;

  localparam logic [15:0] ARB_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != ARB_CNT_MAX)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/qarctan_arb_tag_fifo.sv
// First-word-fall-through FIFO of destination tags, one entry per pair in flight.
// Push and pop may happen in the same cycle; DEPTH must be a power of two.
module qarctan_arb_tag_fifo
  import qarctan_arbiter_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  arb_tag_t      din_i,
  input  logic          pop_i,
  output arb_tag_t      dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  arb_tag_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/qarctan_arbiter.sv
// Round-robin sharing of one qarctan core between two (r, i) requesters,
// with in-order result steering. Statistics counters exist with QARCTAN_ARB_STATS_EN.
module qarctan_arbiter
  import qarctan_arbiter_pkg::*;
#(
  parameter int  DATA_WIDTH   = 32,
  parameter int  MAX_INFLIGHT = 4,
  localparam int CW           = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  req0_r_rd_en,
  output logic                  req0_i_rd_en,
  input  logic                  req0_r_empty,
  input  logic                  req0_i_empty,
  input  logic [DATA_WIDTH-1:0] req0_r_dout,
  input  logic [DATA_WIDTH-1:0] req0_i_dout,
  output logic                  req1_r_rd_en,
  output logic                  req1_i_rd_en,
  input  logic                  req1_r_empty,
  input  logic                  req1_i_empty,
  input  logic [DATA_WIDTH-1:0] req1_r_dout,
  input  logic [DATA_WIDTH-1:0] req1_i_dout,
  output logic                  core_r_wr_en,
  output logic                  core_i_wr_en,
  input  logic                  core_r_full,
  input  logic                  core_i_full,
  output logic [DATA_WIDTH-1:0] core_r_din,
  output logic [DATA_WIDTH-1:0] core_i_din,
  output logic                  core_out_rd_en,
  input  logic                  core_out_empty,
  input  logic [DATA_WIDTH-1:0] core_out_dout,
  output logic                  out0_wr_en,
  input  logic                  out0_full,
  output logic [DATA_WIDTH-1:0] out0_din,
  output logic                  out1_wr_en,
  input  logic                  out1_full,
  output logic [DATA_WIDTH-1:0] out1_din,
  output logic [15:0]           grant0_cnt,
  output logic [15:0]           grant1_cnt,
  output logic [15:0]           stall_cnt,
  output logic                  dbg_state,
  output logic [CW-1:0]         dbg_inflight
);

  // Handshake: every rd_en/wr_en is a one-cycle pulse, asserted only when the
  // target FIFO is non-empty (rd) or non-full (wr); the transfer happens on that edge.

  arb_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic [DATA_WIDTH-1:0] i_q, i_d;
  arb_tag_t              tag_q, tag_d;
  arb_tag_t              last_grant_q, last_grant_d;

  logic     elig0, elig1;
  logic     can_issue;
  logic     grant_vld;
  logic     grant_sel;
  logic     core_ready;
  logic     tag_push, tag_pop;
  logic     tag_empty, tag_full;
  arb_tag_t tag_head;
  logic     ret_go;
  logic [CW-1:0] inflight;

  assign elig0      = !req0_r_empty && !req0_i_empty;
  assign elig1      = !req1_r_empty && !req1_i_empty;
  assign can_issue  = !tag_full;
  assign core_ready = !core_r_full && !core_i_full;

  // On a tie the requester not granted last wins.
  always_comb begin
    grant_sel = 1'b0;
    if (elig0 && elig1) grant_sel = ~last_grant_q;
    else if (elig1)     grant_sel = 1'b1;
  end

  assign grant_vld = (state_q == S_SEL) && can_issue && (elig0 || elig1);

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    i_d          = i_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    req0_r_rd_en = 1'b0;
    req0_i_rd_en = 1'b0;
    req1_r_rd_en = 1'b0;
    req1_i_rd_en = 1'b0;
    core_r_wr_en = 1'b0;
    core_i_wr_en = 1'b0;
    tag_push     = 1'b0;
    case (state_q)
      S_SEL: begin
        if (grant_vld) begin
          if (grant_sel) begin
            req1_r_rd_en = 1'b1;
            req1_i_rd_en = 1'b1;
            r_d          = req1_r_dout;
            i_d          = req1_i_dout;
          end else begin
            req0_r_rd_en = 1'b1;
            req0_i_rd_en = 1'b1;
            r_d          = req0_r_dout;
            i_d          = req0_i_dout;
          end
          tag_d        = grant_sel;
          last_grant_d = grant_sel;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_ready) begin
          core_r_wr_en = 1'b1;
          core_i_wr_en = 1'b1;
          tag_push     = 1'b1;
          state_d      = S_SEL;
        end
      end
      default: state_d = S_SEL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_SEL;
      r_q          <= '0;
      i_q          <= '0;
      tag_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      i_q          <= i_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign core_r_din = r_q;
  assign core_i_din = i_q;

  qarctan_arb_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tag_push),
    .din_i   (tag_q),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full),
    .count_o (inflight)
  );

  // Results return strictly in issue order; a full head destination blocks both.
  assign ret_go         = !core_out_empty && !tag_empty && !(tag_head ? out1_full : out0_full);
  assign tag_pop        = ret_go;
  assign core_out_rd_en = ret_go;
  assign out0_wr_en     = ret_go && (tag_head == 1'b0);
  assign out1_wr_en     = ret_go && (tag_head == 1'b1);
  assign out0_din       = out0_wr_en ? core_out_dout : '0;
  assign out1_din       = out1_wr_en ? core_out_dout : '0;

  assign dbg_state    = state_q;
  assign dbg_inflight = inflight;

`ifdef QARCTAN_ARB_STATS_EN
  logic [15:0] grant0_q, grant1_q, stall_q;
  logic        stall_ev;

  assign stall_ev = ((state_q == S_SEL) && (elig0 || elig1) && tag_full) ||
                    ((state_q == S_ISSUE) && !core_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant0_q <= '0;
      grant1_q <= '0;
      stall_q  <= '0;
    end else begin
      grant0_q <= sat_inc(grant0_q, grant_vld && !grant_sel);
      grant1_q <= sat_inc(grant1_q, grant_vld && grant_sel);
      stall_q  <= sat_inc(stall_q, stall_ev);
    end
  end

  assign grant0_cnt = grant0_q;
  assign grant1_cnt = grant1_q;
  assign stall_cnt  = stall_q;
`else
  assign grant0_cnt = '0;
  assign grant1_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_qarctan_arbiter.sv
// Bench for qarctan_arbiter: behavioural FIFOs and an r+i echo core around the DUT,
// table-driven pair vectors, a per-output expected queue, and directed corner sequences.
module tb_qarctan_arbiter;
  import qarctan_arbiter_pkg::*;

  localparam int W        = 32;
  localparam int MAXF     = 4;
  localparam int CW       = $clog2(MAXF) + 1;
  localparam int CORE_CAP = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          req0_r_rd_en, req0_i_rd_en, req1_r_rd_en, req1_i_rd_en;
  logic          req0_r_empty, req0_i_empty, req1_r_empty, req1_i_empty;
  logic [W-1:0]  req0_r_dout, req0_i_dout, req1_r_dout, req1_i_dout;
  logic          core_r_wr_en, core_i_wr_en, core_r_full, core_i_full;
  logic [W-1:0]  core_r_din, core_i_din;
  logic          core_out_rd_en, core_out_empty;
  logic [W-1:0]  core_out_dout;
  logic          out0_wr_en, out0_full, out1_wr_en, out1_full;
  logic [W-1:0]  out0_din, out1_din;
  logic [15:0]   grant0_cnt, grant1_cnt, stall_cnt;
  logic          dbg_state;
  logic [CW-1:0] dbg_inflight;

  qarctan_arbiter #(.DATA_WIDTH(W), .MAX_INFLIGHT(MAXF)) dut (
    .clock(clock), .reset(reset),
    .req0_r_rd_en(req0_r_rd_en), .req0_i_rd_en(req0_i_rd_en),
    .req0_r_empty(req0_r_empty), .req0_i_empty(req0_i_empty),
    .req0_r_dout(req0_r_dout), .req0_i_dout(req0_i_dout),
    .req1_r_rd_en(req1_r_rd_en), .req1_i_rd_en(req1_i_rd_en),
    .req1_r_empty(req1_r_empty), .req1_i_empty(req1_i_empty),
    .req1_r_dout(req1_r_dout), .req1_i_dout(req1_i_dout),
    .core_r_wr_en(core_r_wr_en), .core_i_wr_en(core_i_wr_en),
    .core_r_full(core_r_full), .core_i_full(core_i_full),
    .core_r_din(core_r_din), .core_i_din(core_i_din),
    .core_out_rd_en(core_out_rd_en), .core_out_empty(core_out_empty),
    .core_out_dout(core_out_dout),
    .out0_wr_en(out0_wr_en), .out0_full(out0_full), .out0_din(out0_din),
    .out1_wr_en(out1_wr_en), .out1_full(out1_full), .out1_din(out1_din),
    .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state), .dbg_inflight(dbg_inflight)
  );

  // environment model state
  logic [W-1:0] rq_r0[$], rq_i0[$], rq_r1[$], rq_i1[$];
  logic [W-1:0] cr_q[$], ci_q[$], cout_q[$];
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int           grant_log[$];
  bit           core_hold, force_r_full, out_full0, out_full1;
  int           checks, failures, cyc;
  int           core_wr_cnt, req_pop_cnt, out_wr_cnt0, out_wr_cnt1;
  int           last_out_cyc0, last_out_cyc1;

  typedef struct {
    int           req;
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic update_inputs();
    req0_r_empty   = (rq_r0.size() == 0);
    req0_i_empty   = (rq_i0.size() == 0);
    req1_r_empty   = (rq_r1.size() == 0);
    req1_i_empty   = (rq_i1.size() == 0);
    req0_r_dout    = req0_r_empty ? '0 : rq_r0[0];
    req0_i_dout    = req0_i_empty ? '0 : rq_i0[0];
    req1_r_dout    = req1_r_empty ? '0 : rq_r1[0];
    req1_i_dout    = req1_i_empty ? '0 : rq_i1[0];
    core_r_full    = force_r_full || (cr_q.size() >= CORE_CAP);
    core_i_full    = (ci_q.size() >= CORE_CAP);
    core_out_empty = (cout_q.size() == 0);
    core_out_dout  = core_out_empty ? '0 : cout_q[0];
    out0_full      = out_full0;
    out1_full      = out_full1;
  endtask

  // Env: sample strobes at negedge, apply FIFO effects just after the posedge.
  initial begin : env
    logic v, rd0, rd1, cw, co, w0, w1;
    logic [W-1:0] cr, ci;
    int sc;
    forever begin
      @(negedge clock);
      cyc++;
      sc = cyc; v = reset;
      rd0 = req0_r_rd_en; rd1 = req1_r_rd_en; cw = core_r_wr_en;
      co = core_out_rd_en; w0 = out0_wr_en; w1 = out1_wr_en;
      cr = core_r_din; ci = core_i_din;
      if (req0_r_rd_en || req0_i_rd_en) begin
        check("req0_rd_both", W'({req0_r_rd_en, req0_i_rd_en}), W'(2'b11));
        check("req0_rd_nonempty", W'({req0_r_empty, req0_i_empty}), W'(2'b00));
        grant_log.push_back(0);
      end
      if (req1_r_rd_en || req1_i_rd_en) begin
        check("req1_rd_both", W'({req1_r_rd_en, req1_i_rd_en}), W'(2'b11));
        check("req1_rd_nonempty", W'({req1_r_empty, req1_i_empty}), W'(2'b00));
        grant_log.push_back(1);
      end
      if (core_r_wr_en || core_i_wr_en) begin
        check("core_wr_both", W'({core_r_wr_en, core_i_wr_en}), W'(2'b11));
        check("core_wr_not_full", W'({core_r_full, core_i_full}), W'(2'b00));
      end
      if (core_out_rd_en) begin
        check("core_pop_nonempty", W'(core_out_empty), W'(1'b0));
        check("core_pop_one_dest", W'(out0_wr_en) + W'(out1_wr_en), W'(1));
      end
      if (out0_wr_en) begin
        check("out0_not_full", W'(out0_full), W'(1'b0));
        check("out1_idle_din", out1_din, '0);
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL out0_unexpected actual=%0h required=no_write", out0_din);
        end else check("out0_data", out0_din, exp_q0.pop_front());
      end
      if (out1_wr_en) begin
        check("out1_not_full", W'(out1_full), W'(1'b0));
        check("out0_idle_din", out0_din, '0);
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL out1_unexpected actual=%0h required=no_write", out1_din);
        end else check("out1_data", out1_din, exp_q1.pop_front());
      end
      @(posedge clock);
      #1;
      if (v && reset) begin
        if (rd0 && rq_r0.size() > 0) begin void'(rq_r0.pop_front()); void'(rq_i0.pop_front()); req_pop_cnt++; end
        if (rd1 && rq_r1.size() > 0) begin void'(rq_r1.pop_front()); void'(rq_i1.pop_front()); req_pop_cnt++; end
        if (cw) begin cr_q.push_back(cr); ci_q.push_back(ci); core_wr_cnt++; end
        if (co && cout_q.size() > 0) void'(cout_q.pop_front());
        if (w0) begin out_wr_cnt0++; last_out_cyc0 = sc; end
        if (w1) begin out_wr_cnt1++; last_out_cyc1 = sc; end
      end
      if (!core_hold && cr_q.size() > 0 && ci_q.size() > 0)
        cout_q.push_back(cr_q.pop_front() + ci_q.pop_front());
      update_inputs();
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input int req, input logic [W-1:0] r, input logic [W-1:0] i,
                      input logic [W-1:0] exp);
    if (req == 0) begin rq_r0.push_back(r); rq_i0.push_back(i); exp_q0.push_back(exp); end
    else          begin rq_r1.push_back(r); rq_i1.push_back(i); exp_q1.push_back(exp); end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    rq_r0.delete(); rq_i0.delete(); rq_r1.delete(); rq_i1.delete();
    cr_q.delete(); ci_q.delete(); cout_q.delete();
    exp_q0.delete(); exp_q1.delete(); grant_log.delete();
    core_hold = 0; force_r_full = 0; out_full0 = 0; out_full1 = 0;
    core_wr_cnt = 0; req_pop_cnt = 0; out_wr_cnt0 = 0; out_wr_cnt1 = 0;
    update_inputs();
    #1;
    check("rst_strobes", W'({req0_r_rd_en, req0_i_rd_en, req1_r_rd_en, req1_i_rd_en,
                             core_r_wr_en, core_i_wr_en, core_out_rd_en, out0_wr_en, out1_wr_en}), '0);
    check("rst_core_r_din", core_r_din, '0);
    check("rst_core_i_din", core_i_din, '0);
    check("rst_out_din", out0_din | out1_din, '0);
    check("rst_state", W'(dbg_state), W'(S_SEL));
    check("rst_inflight", W'(dbg_inflight), '0);
    check("rst_counters", W'({grant0_cnt, grant1_cnt}) | W'(stall_cnt), '0);
    tick();
    tick();
    reset = 1'b1;
    update_inputs();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n;
    vecs[0] = '{0, 32'd1, 32'd2, 32'd3};
    vecs[1] = '{0, 32'd3, 32'd4, 32'd7};
    vecs[2] = '{0, 32'd5, 32'd6, 32'd11};
    for (int k = 3; k < 11; k++) begin
      vecs[k].req = (k - 3) % 2;
      vecs[k].r   = $urandom_range(32'hFFFF_FFFF, 0);
      vecs[k].i   = $urandom_range(32'hFFFF_FFFF, 0);
      vecs[k].exp = vecs[k].r + vecs[k].i;
    end
    checks = 0; failures = 0;
    update_inputs();

    // single requester, three pairs
    do_reset();
    for (int k = 0; k < 3; k++) load(vecs[k].req, vecs[k].r, vecs[k].i, vecs[k].exp);
    update_inputs();
    wait_drain(60);
    check("t1_out0_count", W'(out_wr_cnt0), W'(3));
    check("t1_out1_count", W'(out_wr_cnt1), W'(0));

    // both requesters, strict alternation
    do_reset();
    for (int k = 3; k < 11; k++) load(vecs[k].req, vecs[k].r, vecs[k].i, vecs[k].exp);
    update_inputs();
    wait_drain(100);
    check("t2_grant_total", W'(grant_log.size()), W'(8));
    for (int k = 0; k < 8 && k < grant_log.size(); k++) check("t2_grant_seq", W'(grant_log[k]), W'(k % 2));
`ifdef QARCTAN_ARB_STATS_EN
    check("t2_grant0_cnt", W'(grant0_cnt), W'(4));
    check("t2_grant1_cnt", W'(grant1_cnt), W'(4));
`else
    check("t2_grant_cnt_tied", W'({grant0_cnt, grant1_cnt}), '0);
`endif

    // in-flight limit with core results held back
    do_reset();
    core_hold = 1;
    for (int k = 0; k < 6; k++) load(0, W'(k * 10), W'(k), W'(k * 11));
    update_inputs();
    repeat (30) tick();
    check("t3_inflight_cap", W'(dbg_inflight), W'(MAXF));
    check("t3_issued", W'(req_pop_cnt), W'(4));
    check("t3_state", W'(dbg_state), W'(S_SEL));
`ifdef QARCTAN_ARB_STATS_EN
    check("t3_stall_nonzero", W'(stall_cnt != 16'd0), W'(1'b1));
`else
    check("t3_stall_tied", W'(stall_cnt), '0);
`endif
    core_hold = 0;
    update_inputs();
    wait_drain(80);
    check("t3_issued_all", W'(req_pop_cnt), W'(6));
    check("t3_inflight_zero", W'(dbg_inflight), '0);

    // head-of-line blocking on out0
    do_reset();
    out_full0 = 1;
    load(0, 32'd100, 32'd1, 32'd101);
    load(1, 32'd200, 32'd2, 32'd202);
    update_inputs();
    repeat (15) tick();
    check("t4_no_out0", W'(out_wr_cnt0), '0);
    check("t4_no_out1", W'(out_wr_cnt1), '0);
    check("t4_core_results_held", W'(cout_q.size()), W'(2));
    check("t4_inflight", W'(dbg_inflight), W'(2));
    out_full0 = 0;
    update_inputs();
    wait_drain(20);
    check("t4_out_counts", W'({out_wr_cnt0[7:0], out_wr_cnt1[7:0]}), W'(16'h0101));
    check("t4_consecutive", W'(last_out_cyc1 - last_out_cyc0), W'(1));

    // core_r_full held while a pair is captured
    do_reset();
    force_r_full = 1;
    load(0, 32'd7, 32'd8, 32'd15);
    load(0, 32'd9, 32'd10, 32'd19);
    update_inputs();
    n = 0;
    while (dbg_state != S_ISSUE && n < 10) begin tick(); n++; end
    check("t5_reached_issue", W'(dbg_state), W'(S_ISSUE));
    check("t5_one_pop", W'(req_pop_cnt), W'(1));
    repeat (5) tick();
    check("t5_no_more_pops", W'(req_pop_cnt), W'(1));
    check("t5_no_core_wr", W'(core_wr_cnt), '0);
    check("t5_hold_r", core_r_din, 32'd7);
    check("t5_hold_i", core_i_din, 32'd8);
    check("t5_still_issue", W'(dbg_state), W'(S_ISSUE));
    force_r_full = 0;
    update_inputs();
    tick();
    check("t5_wr_on_release", W'(core_wr_cnt), W'(1));
    wait_drain(40);

    // reset with pairs in flight
    do_reset();
    core_hold = 1;
    load(1, 32'd1, 32'd1, 32'd2);
    load(1, 32'd2, 32'd2, 32'd4);
    update_inputs();
    repeat (8) tick();
    check("t6_inflight_pre", W'(dbg_inflight), W'(2));
    do_reset();
    check("t6_inflight_post", W'(dbg_inflight), '0);
    check("t6_state_post", W'(dbg_state), W'(S_SEL));
    load(0, 32'd3, 32'd3, 32'd6);
    load(1, 32'd4, 32'd4, 32'd8);
    update_inputs();
    n = 0;
    while (grant_log.size() == 0 && n < 10) begin tick(); n++; end
    check("t6_first_grant_seen", W'(grant_log.size() > 0), W'(1'b1));
    if (grant_log.size() > 0) check("t6_first_grant_req0", W'(grant_log[0]), '0);
    wait_drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
